rf_scoreboard: RTL and testbench

Parametrised integer register file with multiple read and write ports, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It sits between decode/issue and writeback in the pipelined core. Issue reserves a destination register and writeback releases it, so the hazard logic reads busy status directly from this block. It also drives the flat architectural-state snapshot used by difftest.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_scoreboard_if.sv | 33 +++
 rtl/rf_pend_cnt.sv | 30 +++
 rtl/rf_scoreboard.sv | 119 +++++++++++
 tb/tb_rf_scoreboard.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared constants for the integer register file: default sizes, ABI register indices
// and the pending-counter type.
package rf_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = $clog2(NREG_DEF);
  localparam int unsigned CNTW_DEF = 2;

  typedef logic [CNTW_DEF-1:0] cnt_t;
  typedef logic [AW_DEF-1:0]   reg_idx_t;

  // RISC-V ABI aliases
  localparam reg_idx_t ZERO = reg_idx_t'(0),  RA  = reg_idx_t'(1),  SP  = reg_idx_t'(2),  GP  = reg_idx_t'(3);
  localparam reg_idx_t TP   = reg_idx_t'(4),  T0  = reg_idx_t'(5),  T1  = reg_idx_t'(6),  T2  = reg_idx_t'(7);
  localparam reg_idx_t S0   = reg_idx_t'(8),  S1  = reg_idx_t'(9),  A0  = reg_idx_t'(10), A1  = reg_idx_t'(11);
  localparam reg_idx_t A2   = reg_idx_t'(12), A3  = reg_idx_t'(13), A4  = reg_idx_t'(14), A5  = reg_idx_t'(15);
  localparam reg_idx_t A6   = reg_idx_t'(16), A7  = reg_idx_t'(17), S2  = reg_idx_t'(18), S3  = reg_idx_t'(19);
  localparam reg_idx_t S4   = reg_idx_t'(20), S5  = reg_idx_t'(21), S6  = reg_idx_t'(22), S7  = reg_idx_t'(23);
  localparam reg_idx_t S8   = reg_idx_t'(24), S9  = reg_idx_t'(25), S10 = reg_idx_t'(26), S11 = reg_idx_t'(27);
  localparam reg_idx_t T3   = reg_idx_t'(28), T4  = reg_idx_t'(29), T5  = reg_idx_t'(30), T6  = reg_idx_t'(31);

endpackage

// File: rtl/rf_scoreboard_if.sv
// Read, issue, writeback and snapshot signals of the register file scoreboard.
interface rf_scoreboard_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 2
);
  localparam int unsigned AW = $clog2(NREG);

  logic [NRD-1:0]       rd_en;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 iss_valid;
  logic [AW-1:0]        iss_rd;
  logic                 iss_ready;
  logic [NWR-1:0]       wb_valid;
  logic [NWR*AW-1:0]    wb_addr;
  logic [NWR*XLEN-1:0]  wb_data;
  logic                 flush;
  logic                 err;
  logic [NREG*XLEN-1:0] regs_snap;

  modport master (
    output rd_en, rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, iss_ready, err, regs_snap
  );

  modport slave (
    input  rd_en, rd_addr, iss_valid, iss_rd, wb_valid, wb_addr, wb_data, flush,
    output rd_data, rd_busy, iss_ready, err, regs_snap
  );
endinterface

// File: rtl/rf_pend_cnt.sv
// Pending-write counter for one register: +inc, -dec_n, clamps to inc on underflow.
module rf_pend_cnt
  import rf_pkg::*;
#(
  parameter int unsigned CNTW = CNTW_DEF,
  parameter int unsigned NW   = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic [NW-1:0]   dec_n,
  input  logic            flush,
  output logic [CNTW-1:0] cnt,
  output logic            underflow
);
  localparam int unsigned SW = ((CNTW > NW) ? CNTW : NW) + 1;

  // Flushed writebacks are neither counted nor checked
  assign underflow = !flush && (SW'(dec_n) > SW'(cnt));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt <= '0;
    end else if (underflow) begin
      cnt <= CNTW'(inc);
    end else begin
      cnt <= CNTW'(SW'(cnt) + SW'(inc) - SW'(dec_n));
    end
  end
endmodule

// File: rtl/rf_scoreboard.sv
// Multi-port register file with same-cycle writeback bypass, per-register pending-write
// scoreboard and a flat architectural snapshot.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned NREG   = NREG_DEF,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned CNTW   = CNTW_DEF,
  parameter int unsigned BYPASS = 1
) (
  input logic            clk,
  input logic            rst,
  rf_scoreboard_if.slave bus
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned NW = $clog2(NWR + 1);
  localparam int unsigned SW = ((CNTW > NW) ? CNTW : NW) + 1;
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic [XLEN-1:0] regs   [NREG];
  logic [XLEN-1:0] wb_win [NREG];
  logic [NW-1:0]   nwb    [NREG];
  logic [CNTW-1:0] cnt    [NREG];
  logic [NREG-1:0] wb_hit;
  logic [NREG-1:0] uf;
  logic [AW-1:0]   ra;
  logic            iss_fire;
  logic            err_q;

  // Write-port priority: later ports override earlier ones; x0 never matches
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wb_hit[r] = 1'b0;
      wb_win[r] = '0;
      nwb[r]    = '0;
    end
    for (int r = 1; r < NREG; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (bus.wb_valid[p] && (bus.wb_addr[p*AW +: AW] == AW'(r))) begin
          wb_hit[r] = 1'b1;
          wb_win[r] = bus.wb_data[p*XLEN +: XLEN];
          nwb[r]    = nwb[r] + NW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    regs[0] <= '0;
    for (int r = 1; r < NREG; r++) begin
      if (rst) begin
        regs[r] <= '0;
      end else if (wb_hit[r]) begin
        regs[r] <= wb_win[r];
      end
    end
  end

  assign bus.iss_ready = !rst && ((bus.iss_rd == '0) || (cnt[bus.iss_rd] != CNT_MAX));
  assign iss_fire      = bus.iss_valid && bus.iss_ready && !bus.flush;

  assign cnt[0] = '0;
  assign uf[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    rf_pend_cnt #(.CNTW(CNTW), .NW(NW)) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (iss_fire && (bus.iss_rd == AW'(r))),
      .dec_n     (nwb[r]),
      .flush     (bus.flush),
      .cnt       (cnt[r]),
      .underflow (uf[r])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|uf) begin
      err_q <= 1'b1;
    end
  end
  assign bus.err = err_q;

  // Read ports; with bypass, busy excludes writes retiring this cycle
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    ra          = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = bus.rd_addr[k*AW +: AW];
      if (!rst && bus.rd_en[k]) begin
        if ((BYPASS != 0) && wb_hit[ra]) begin
          bus.rd_data[k*XLEN +: XLEN] = wb_win[ra];
        end else begin
          bus.rd_data[k*XLEN +: XLEN] = regs[ra];
        end
        if (BYPASS != 0) begin
          bus.rd_busy[k] = SW'(cnt[ra]) > SW'(nwb[ra]);
        end else begin
          bus.rd_busy[k] = cnt[ra] != '0;
        end
      end
    end
  end

  // Snapshot shows post-commit state
  always_comb begin
    bus.regs_snap = '0;
    if (!rst) begin
      for (int r = 1; r < NREG; r++) begin
        bus.regs_snap[r*XLEN +: XLEN] = wb_hit[r] ? wb_win[r] : regs[r];
      end
    end
  end
endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed and randomized checks of rf_scoreboard against a per-register
// array/counter reference model.
module tb_rf_scoreboard;
  import rf_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NREG = 32;
  localparam int unsigned NRD  = 2;
  localparam int unsigned NWR  = 2;
  localparam int unsigned CNTW = 2;
  localparam int unsigned AW   = 5;
  localparam int          CMAX = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .CNTW(CNTW), .BYPASS(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [XLEN-1:0] m_regs [NREG];
  int              m_cnt  [NREG];
  bit              m_err;
  int              tests = 0;
  int              fails = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nwb_of(input int r);
    int n = 0;
    for (int p = 0; p < NWR; p++)
      if (r != 0 && bus.wb_valid[p] && int'(bus.wb_addr[p*AW +: AW]) == r) n++;
    return n;
  endfunction

  function automatic logic [XLEN-1:0] fwd(input int r, output bit hit);
    logic [XLEN-1:0] d = '0;
    hit = 1'b0;
    for (int p = 0; p < NWR; p++)
      if (r != 0 && bus.wb_valid[p] && int'(bus.wb_addr[p*AW +: AW]) == r) begin
        hit = 1'b1;
        d   = bus.wb_data[p*XLEN +: XLEN];
      end
    return d;
  endfunction

  function automatic bit exp_ready();
    return !rst && (bus.iss_rd == ZERO || m_cnt[int'(bus.iss_rd)] != CMAX);
  endfunction

  // Compare every combinational output against the model for the current inputs
  task automatic model_check();
    bit              hit;
    logic [XLEN-1:0] d, e_d;
    bit              e_b;
    int              a;
    for (int k = 0; k < NRD; k++) begin
      a   = int'(bus.rd_addr[k*AW +: AW]);
      e_d = '0;
      e_b = 1'b0;
      if (!rst && bus.rd_en[k]) begin
        d   = fwd(a, hit);
        e_d = hit ? d : m_regs[a];
        e_b = (a != 0) && (m_cnt[a] - nwb_of(a) > 0);
      end
      check($sformatf("rd_data%0d", k), bus.rd_data[k*XLEN +: XLEN], e_d);
      check($sformatf("rd_busy%0d", k), 64'(bus.rd_busy[k]), 64'(e_b));
    end
    check("iss_ready", 64'(bus.iss_ready), 64'(exp_ready()));
    check("err", 64'(bus.err), 64'(m_err));
    for (int r = 0; r < NREG; r++) begin
      d = fwd(r, hit);
      check($sformatf("snap%0d", r), bus.regs_snap[r*XLEN +: XLEN], rst ? '0 : (hit ? d : m_regs[r]));
    end
  endtask

  // Advance the model across one clock edge using the inputs present at that edge
  task automatic model_step();
    int n [NREG];
    bit fire;
    int inc;
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
      m_err = 1'b0;
    end else begin
      fire = bus.iss_valid && exp_ready() && !bus.flush;
      for (int r = 0; r < NREG; r++) n[r] = nwb_of(r);
      for (int p = 0; p < NWR; p++)
        if (bus.wb_valid[p] && bus.wb_addr[p*AW +: AW] != ZERO)
          m_regs[int'(bus.wb_addr[p*AW +: AW])] = bus.wb_data[p*XLEN +: XLEN];
      for (int r = 1; r < NREG; r++) begin
        inc = (fire && int'(bus.iss_rd) == r) ? 1 : 0;
        if (bus.flush) m_cnt[r] = 0;
        else if (n[r] > m_cnt[r]) begin m_err = 1'b1; m_cnt[r] = inc; end
        else m_cnt[r] = m_cnt[r] + inc - n[r];
      end
    end
  endtask

  task automatic half();  @(negedge clk); model_check(); endtask
  task automatic fin();   @(posedge clk); model_step(); #1; endtask
  task automatic cycle(); half(); fin(); endtask

  task automatic idle();
    bus.rd_en = '0; bus.rd_addr = '0; bus.iss_valid = 1'b0; bus.iss_rd = '0;
    bus.wb_valid = '0; bus.wb_addr = '0; bus.wb_data = '0; bus.flush = 1'b0;
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) begin m_regs[r] = '0; m_cnt[r] = 0; end
    m_err = 1'b0;
    idle();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;

    // Reset state of every register
    for (int r = 1; r < NREG; r++) begin
      bus.rd_en = 2'b11; bus.rd_addr = {AW'(r), AW'(r)};
      half();
      check("rst_data", bus.rd_data[0 +: XLEN], '0);
      check("rst_busy", 64'(bus.rd_busy), '0);
      fin();
    end
    check("rst_ready", 64'(bus.iss_ready), 64'd1);

    // Issue then writeback x5 through the bypass
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = T0;
    cycle();
    idle(); bus.rd_en = 2'b01; bus.rd_addr = {AW'(0), T0};
    half(); check("busy_x5", 64'(bus.rd_busy[0]), 64'd1); fin();
    bus.wb_valid = 2'b01; bus.wb_addr = {AW'(0), T0}; bus.wb_data = {64'd0, 64'hDEAD_BEEF};
    half();
    check("byp_x5", bus.rd_data[0 +: XLEN], 64'hDEAD_BEEF);
    check("byp_busy_x5", 64'(bus.rd_busy[0]), 64'd0);
    fin();
    bus.wb_valid = '0;
    half(); check("reg_x5", bus.rd_data[0 +: XLEN], 64'hDEAD_BEEF); fin();

    // Saturate x7, then free one slot
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = T2;
    cycle(); cycle(); cycle();
    half(); check("sat_ready", 64'(bus.iss_ready), 64'd0); fin();
    bus.wb_valid = 2'b01; bus.wb_addr = {AW'(0), T2}; bus.wb_data = {64'd0, 64'h77};
    half(); check("sat_wb_ready", 64'(bus.iss_ready), 64'd0); fin();
    bus.wb_valid = '0;
    half(); check("unsat_ready", 64'(bus.iss_ready), 64'd1); fin();

    // Two ports writing x3 in one cycle
    idle(); bus.iss_valid = 1'b1; bus.iss_rd = GP;
    cycle(); cycle();
    idle(); bus.wb_valid = 2'b11; bus.wb_addr = {GP, GP}; bus.wb_data = {64'd2, 64'd1};
    cycle();
    idle(); bus.rd_en = 2'b10; bus.rd_addr = {GP, AW'(0)};
    half();
    check("conf_x3", bus.rd_data[XLEN +: XLEN], 64'd2);
    check("conf_busy", 64'(bus.rd_busy[1]), 64'd0);
    check("conf_err", 64'(bus.err), 64'd0);
    fin();

    // Unreserved writeback and writes to x0
    idle(); bus.wb_valid = 2'b01; bus.wb_addr = {AW'(0), S1}; bus.wb_data = {64'd0, 64'h99};
    cycle();
    idle(); bus.rd_en = 2'b01; bus.rd_addr = {AW'(0), S1};
    half(); check("uf_err", 64'(bus.err), 64'd1); check("uf_x9", bus.rd_data[0 +: XLEN], 64'h99); fin();
    bus.rd_addr = {AW'(0), ZERO}; bus.wb_valid = 2'b10; bus.wb_addr = {ZERO, AW'(0)}; bus.wb_data = {64'd5, 64'd0};
    half(); check("x0_byp", bus.rd_data[0 +: XLEN], 64'd0); fin();
    bus.wb_valid = '0;
    half(); check("x0_reg", bus.rd_data[0 +: XLEN], 64'd0); check("x0_err", 64'(bus.err), 64'd1); fin();

    // Flush with an outstanding reservation and same-cycle write
    idle(); rst = 1'b1; cycle(); rst = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_rd = TP; cycle();
    bus.iss_rd = T1; cycle();
    bus.iss_rd = S0; bus.flush = 1'b1;
    bus.wb_valid = 2'b01; bus.wb_addr = {AW'(0), TP}; bus.wb_data = {64'd0, 64'h11};
    cycle();
    idle(); bus.rd_en = 2'b11; bus.rd_addr = {T1, TP};
    half();
    check("fl_x4", bus.rd_data[0 +: XLEN], 64'h11);
    check("fl_busy", 64'(bus.rd_busy), 64'd0);
    check("fl_err", 64'(bus.err), 64'd0);
    fin();
    bus.rd_addr = {S0, S0};
    half(); check("fl_drop_x8", 64'(bus.rd_busy), 64'd0); fin();

    // Randomized traffic over a small register window
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.flush     = ($urandom_range(0, 31) == 0);
      bus.iss_valid = $urandom_range(0, 1) == 1;
      bus.iss_rd    = AW'($urandom_range(0, 7));
      for (int p = 0; p < NWR; p++) begin
        bus.wb_valid[p]               = ($urandom_range(0, 3) == 0);
        bus.wb_addr[p*AW +: AW]       = AW'($urandom_range(0, 7));
        bus.wb_data[p*XLEN +: XLEN]   = {$urandom, $urandom};
      end
      for (int k = 0; k < NRD; k++) begin
        bus.rd_en[k]            = ($urandom_range(0, 3) != 0);
        bus.rd_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
